// File: rtl/pwm_capture_device.sv
// PWM capture peripheral: measures high time and period on CHANNELS asynchronous
// inputs and exposes results, W1C status flags and a level interrupt on the local bus.
module pwm_capture_device #(
  parameter int ID       = 1,
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                peripheralEnable,
  input  logic                peripheralBus_we,
  input  logic                peripheralBus_oe,
  output logic                peripheralBus_busy,
  input  logic [15:0]         peripheralBus_address,
  input  logic [3:0]          peripheralBus_byteSelect,
  input  logic [31:0]         peripheralBus_dataWrite,
  output logic [31:0]         peripheralBus_dataRead,
  output logic                requestOutput,
  input  logic [CHANNELS-1:0] capture_in,
  output logic                capture_irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_e;

  localparam logic [3:0]       DEV_ID  = 4'(ID);
  localparam logic [7:0]       CH_END  = 8'(16 + 8 * CHANNELS);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [CHANNELS-1:0] sync1_q, sync2_q, sync3_q;
  logic [CHANNELS-1:0] rise, fall, cap;
  state_e              state_q  [CHANNELS];
  state_e              state_d  [CHANNELS];
  logic [WIDTH-1:0]    cnt_q    [CHANNELS];
  logic [WIDTH-1:0]    cnt_d    [CHANNELS];
  logic [WIDTH-1:0]    hlat_q   [CHANNELS];
  logic [WIDTH-1:0]    hlat_d   [CHANNELS];
  logic [WIDTH-1:0]    high_q   [CHANNELS];
  logic [WIDTH-1:0]    high_d   [CHANNELS];
  logic [WIDTH-1:0]    period_q [CHANNELS];
  logic [WIDTH-1:0]    period_d [CHANNELS];
  logic                enable_q, enable_d;
  logic [CHANNELS-1:0] irq_en_q, irq_en_d;
  logic [CHANNELS-1:0] valid_q, valid_d, ovf_q, ovf_d;
  logic [CHANNELS-1:0] clr_valid, clr_ovf;
  logic                irq_q, irq_d;

  logic        hit, wr_cfg, wr_stat, rd_hit;
  logic [7:0]  offset;
  logic [2:0]  ch_idx;
  logic [31:0] rd_data;
  logic        unused_bus;

  assign offset   = peripheralBus_address[7:0];
  assign ch_idx   = 3'((offset - 8'h10) >> 3);
  assign hit      = peripheralEnable && (peripheralBus_address[11:8] == DEV_ID);
  assign wr_cfg   = hit && peripheralBus_we && (offset == 8'h00);
  assign wr_stat  = hit && peripheralBus_we && (offset == 8'h04);
  assign rise     = sync2_q & ~sync3_q;
  assign fall     = ~sync2_q & sync3_q;
  assign unused_bus = ^{peripheralBus_address[15:12], peripheralBus_dataWrite,
                        peripheralBus_byteSelect};

  always_comb begin : reg_write
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    enable_d  = enable_q;
    irq_en_d  = irq_en_q;
    clr_valid = '0;
    clr_ovf   = '0;
    if (wr_cfg) begin
      if (peripheralBus_byteSelect[0]) enable_d = peripheralBus_dataWrite[0];
      for (int i = 0; i < CHANNELS; i++)
        if (peripheralBus_byteSelect[(4 + i) / 8]) irq_en_d[i] = peripheralBus_dataWrite[4 + i];
    end
    if (wr_stat) begin
      if (peripheralBus_byteSelect[0]) clr_valid = peripheralBus_dataWrite[CHANNELS-1:0];
      if (peripheralBus_byteSelect[1]) clr_ovf   = peripheralBus_dataWrite[8 +: CHANNELS];
    end
  end

  always_comb begin : fsm_next
    cap = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      state_d[n]  = state_q[n];
      cnt_d[n]    = (cnt_q[n] == CNT_MAX) ? CNT_MAX : cnt_q[n] + 1'b1;
      hlat_d[n]   = hlat_q[n];
      high_d[n]   = high_q[n];
      period_d[n] = period_q[n];
      if (!enable_q) begin
        state_d[n] = ST_IDLE;
        cnt_d[n]   = '0;
      end else begin
        case (state_q[n])
          ST_IDLE: begin
            cnt_d[n] = '0;
            if (rise[n]) begin
              state_d[n] = ST_HIGH;
              cnt_d[n]   = WIDTH'(1);
            end
          end
          ST_HIGH: begin
            // A rise without a seen fall commits the whole period as high time.
            if (rise[n]) begin
              cap[n]      = 1'b1;
              high_d[n]   = cnt_q[n];
              period_d[n] = cnt_q[n];
              cnt_d[n]    = WIDTH'(1);
            end else if (fall[n]) begin
              hlat_d[n]  = cnt_q[n];
              state_d[n] = ST_LOW;
            end
          end
          ST_LOW: begin
            if (rise[n]) begin
              cap[n]      = 1'b1;
              high_d[n]   = hlat_q[n];
              period_d[n] = cnt_q[n];
              cnt_d[n]    = WIDTH'(1);
              state_d[n]  = ST_HIGH;
            end
          end
          default: state_d[n] = ST_IDLE;
        endcase
      end
    end
  end

  // Hardware set takes priority over a same-cycle software clear.
  assign valid_d = (valid_q & ~clr_valid) | cap;
  assign ovf_d   = (ovf_q & ~clr_ovf) | (cap & valid_q);
  assign irq_d   = |(valid_d & irq_en_d);

  always_comb begin : reg_read
    rd_hit  = 1'b0;
    rd_data = '0;
    if (offset == 8'h00) begin
      rd_hit            = 1'b1;
      rd_data[0]        = enable_q;
      rd_data[4 +: CHANNELS] = irq_en_q;
    end else if (offset == 8'h04) begin
      rd_hit                 = 1'b1;
      rd_data[CHANNELS-1:0]  = valid_q;
      rd_data[8 +: CHANNELS] = ovf_q;
    end else if (offset >= 8'h10 && offset < CH_END && offset[1:0] == 2'b00) begin
      rd_hit = 1'b1;
      for (int n = 0; n < CHANNELS; n++)
        if (ch_idx == 3'(n)) rd_data = 32'(offset[2] ? period_q[n] : high_q[n]);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      sync3_q  <= '0;
      enable_q <= 1'b0;
      irq_en_q <= '0;
      valid_q  <= '0;
      ovf_q    <= '0;
      irq_q    <= 1'b0;
      // NOTE: the per-channel arrays are plain flops, not RAM, so they take reset too.
      for (int n = 0; n < CHANNELS; n++) begin
        state_q[n]  <= ST_IDLE;
        cnt_q[n]    <= '0;
        hlat_q[n]   <= '0;
        high_q[n]   <= '0;
        period_q[n] <= '0;
      end
    end else begin
      sync1_q  <= capture_in;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      enable_q <= enable_d;
      irq_en_q <= irq_en_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
      for (int n = 0; n < CHANNELS; n++) begin
        state_q[n]  <= state_d[n];
        cnt_q[n]    <= cnt_d[n];
        hlat_q[n]   <= hlat_d[n];
        high_q[n]   <= high_d[n];
        period_q[n] <= period_d[n];
      end
    end
  end

  assign peripheralBus_busy     = 1'b0;
  assign requestOutput          = hit && peripheralBus_oe && rd_hit;
  assign peripheralBus_dataRead = requestOutput ? rd_data : 32'h0;
  assign capture_irq            = irq_q;

endmodule
